// File: rtl/dsam_stream_encoder.sv
// dsam_stream_encoder
//   Streaming dictionary encoder. The block keeps the last CHANNELS raw words.
//   Each accepted word is XORed against the dictionary entry that gives the
//   result with the lowest Hamming weight. The index of that entry is sent
//   with the word so that a matching decoder can reverse the XOR. A bypass
//   input passes raw words through and still updates the dictionary. A flush
//   input clears the dictionary so that the decoder can be resynchronised.
//
// Parameters
//   DATA_WIDTH  width of the data words
//   CHANNELS    number of dictionary entries (2..16, any value)
//   ADDR_WIDTH  width of the entry index, equal to clog2(CHANNELS)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous reset, active low
//   in_data    raw input word
//   in_valid   in_data is valid
//   in_ready   encoder can take a word this cycle
//   bypass     1 = send the raw word (sampled with each accepted word)
//   flush      synchronous dictionary clear
//   out_data   encoded word
//   out_idx    dictionary index used for encoding
//   out_valid  out_data/out_idx are valid
//   out_ready  downstream takes the output this cycle
module dsam_stream_encoder #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  bypass,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_idx,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int CNT_WIDTH = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] dict [CHANNELS];
    logic [ADDR_WIDTH-1:0] ptr;

    logic                  accept;
    logic [DATA_WIDTH-1:0] best_d;
    logic [CNT_WIDTH-1:0]  best_w;
    logic [ADDR_WIDTH-1:0] best_k;
    logic [DATA_WIDTH-1:0] cand_d;
    logic [CNT_WIDTH-1:0]  cand_w;

    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [DATA_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            cnt = cnt + CNT_WIDTH'(v[i]);
        end
        return cnt;
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Minimum-weight search over the dictionary as it was before this edge.
    // The strict less-than keeps the lowest index when weights are equal.
    always_comb begin
        best_d = in_data ^ dict[0];
        best_w = popcount(in_data ^ dict[0]);
        best_k = '0;
        cand_d = '0;
        cand_w = '0;
        for (int unsigned k = 1; k < CHANNELS; k++) begin
            cand_d = in_data ^ dict[k];
            cand_w = popcount(cand_d);
            if (cand_w < best_w) begin
                best_d = cand_d;
                best_w = cand_w;
                best_k = ADDR_WIDTH'(k);
            end
        end
    end

    // Dictionary and replacement pointer. Flush wins over storing the
    // accepted word. The word is still encoded by the output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                dict[k] <= '0;
            end
            ptr <= '0;
        end else if (flush) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                dict[k] <= '0;
            end
            ptr <= '0;
        end else if (accept) begin
            dict[ptr] <= in_data;
            ptr       <= (ptr == ADDR_WIDTH'(CHANNELS - 1)) ? '0 : ptr + 1'b1;
        end
    end

    // Output register. Data and index are held after out_valid drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            out_data  <= bypass ? in_data : best_d;
            out_idx   <= bypass ? '0 : best_k;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dsam_stream_encoder.sv
module tb_dsam_stream_encoder;

    logic        clk;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        bypass;
    logic        flush;
    logic [15:0] out_data;
    logic [1:0]  out_idx;
    logic        out_valid;
    logic        out_ready;

    int checks;
    int failures;

    dsam_stream_encoder #(
        .DATA_WIDTH(16),
        .CHANNELS  (4),
        .ADDR_WIDTH(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bypass   (bypass),
        .flush    (flush),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic b, input logic f);
        in_data  = d;
        bypass   = b;
        flush    = f;
        in_valid = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", out_data); end
        checks++; if (out_idx !== 2'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", out_idx); end
        checks++; if (dut.ptr !== 2'd0) begin failures++; $display("FAIL reset_ptr got=%0d exp=0", dut.ptr); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        reset = 1'b1;
    endtask

    task automatic test_stream();
        // Empty dictionary: all weights equal, so idx0 and the raw word.
        push(16'h6396, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream0_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 16'h6396) begin failures++; $display("FAIL stream0_data got=%h exp=6396", out_data); end
        checks++; if (out_idx !== 2'd0) begin failures++; $display("FAIL stream0_idx got=%0d exp=0", out_idx); end
        // 0x65B2 ^ 0x6396 = 0x0624 (w4), while the zero entries give w8.
        push(16'h65B2, 1'b0, 1'b0);
        checks++; if (out_data !== 16'h0624) begin failures++; $display("FAIL stream1_data got=%h exp=0624", out_data); end
        checks++; if (out_idx !== 2'd0) begin failures++; $display("FAIL stream1_idx got=%0d exp=0", out_idx); end
        checks++; if (dut.ptr !== 2'd2) begin failures++; $display("FAIL stream1_ptr got=%0d exp=2", dut.ptr); end
    endtask

    task automatic test_tie_break();
        // 0x63B2: entry0 gives 0x0024 (w2) and entry1 gives 0x0600 (w2).
        push(16'h63B2, 1'b0, 1'b0);
        checks++; if (out_data !== 16'h0024) begin failures++; $display("FAIL tie_data got=%h exp=0024", out_data); end
        checks++; if (out_idx !== 2'd0) begin failures++; $display("FAIL tie_idx got=%0d exp=0", out_idx); end
        checks++; if (dut.ptr !== 2'd3) begin failures++; $display("FAIL tie_ptr got=%0d exp=3", dut.ptr); end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 16'h0024) begin failures++; $display("FAIL idle_hold_data got=%h exp=0024", out_data); end
        checks++; if (dut.ptr !== 2'd3) begin failures++; $display("FAIL idle_ptr got=%0d exp=3", dut.ptr); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_d [5];
        logic [1:0]  exp_k [5];
        logic [15:0] words [5];
        // These values follow from the minimum-weight rule. The empty entries
        // give weight 1 for a one-hot word, so words 2..4 select the next
        // empty slot. The fifth word ties at w2 across {1,2,4,8}, so idx0 wins.
        words = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010};
        exp_d = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0011};
        exp_k = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        #2;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(words[i], 1'b0, 1'b0);
            checks++; if (out_data !== exp_d[i]) begin failures++; $display("FAIL wrap%0d_data got=%h exp=%h", i, out_data, exp_d[i]); end
            checks++; if (out_idx !== exp_k[i]) begin failures++; $display("FAIL wrap%0d_idx got=%0d exp=%0d", i, out_idx, exp_k[i]); end
        end
        checks++; if (dut.ptr !== 2'd1) begin failures++; $display("FAIL wrap_ptr got=%0d exp=1", dut.ptr); end
        checks++; if (dut.dict[0] !== 16'h0010) begin failures++; $display("FAIL wrap_dict0 got=%h exp=0010", dut.dict[0]); end
    endtask

    task automatic test_backpressure();
        // dict {0010,0002,0004,0008}: 0x0003 ^ 0x0002 = 0x0001 (w1), idx1.
        push(16'h0003, 1'b0, 1'b0);
        checks++; if (out_data !== 16'h0001) begin failures++; $display("FAIL bp_pre_data got=%h exp=0001", out_data); end
        checks++; if (out_idx !== 2'd1) begin failures++; $display("FAIL bp_pre_idx got=%0d exp=1", out_idx); end
        out_ready = 1'b0;
        in_data   = 16'h00F0;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp%0d_in_ready got=%b exp=0", c, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp%0d_valid got=%b exp=1", c, out_valid); end
            checks++; if (out_data !== 16'h0001) begin failures++; $display("FAIL bp%0d_data got=%h exp=0001", c, out_data); end
            checks++; if (out_idx !== 2'd1) begin failures++; $display("FAIL bp%0d_idx got=%0d exp=1", c, out_idx); end
            checks++; if (dut.ptr !== 2'd2) begin failures++; $display("FAIL bp%0d_ptr got=%0d exp=2", c, dut.ptr); end
            checks++; if (dut.dict[2] !== 16'h0004) begin failures++; $display("FAIL bp%0d_dict2 got=%h exp=0004", c, dut.dict[2]); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
        tick();
        // dict {0010,0003,0004,0008}: 0x00F0 ^ 0x0010 = 0x00E0 (w3) is lowest.
        checks++; if (out_data !== 16'h00E0) begin failures++; $display("FAIL bp_next_data got=%h exp=00e0", out_data); end
        checks++; if (out_idx !== 2'd0) begin failures++; $display("FAIL bp_next_idx got=%0d exp=0", out_idx); end
        checks++; if (dut.dict[2] !== 16'h00F0) begin failures++; $display("FAIL bp_next_dict2 got=%h exp=00f0", dut.dict[2]); end
        checks++; if (dut.ptr !== 2'd3) begin failures++; $display("FAIL bp_next_ptr got=%0d exp=3", dut.ptr); end
    endtask

    task automatic test_bypass_flush();
        push(16'hABCD, 1'b1, 1'b0);
        checks++; if (out_data !== 16'hABCD) begin failures++; $display("FAIL byp_data got=%h exp=abcd", out_data); end
        checks++; if (out_idx !== 2'd0) begin failures++; $display("FAIL byp_idx got=%0d exp=0", out_idx); end
        checks++; if (dut.dict[3] !== 16'hABCD) begin failures++; $display("FAIL byp_dict3 got=%h exp=abcd", dut.dict[3]); end
        checks++; if (dut.ptr !== 2'd0) begin failures++; $display("FAIL byp_ptr got=%0d exp=0", dut.ptr); end
        // dict {0010,0003,00F0,ABCD}: 0x1234 ^ 0x0010 = 0x1224 (w4) is lowest.
        push(16'h1234, 1'b0, 1'b1);
        flush = 1'b0;
        checks++; if (out_data !== 16'h1224) begin failures++; $display("FAIL flush_data got=%h exp=1224", out_data); end
        checks++; if (out_idx !== 2'd0) begin failures++; $display("FAIL flush_idx got=%0d exp=0", out_idx); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL flush_valid got=%b exp=1", out_valid); end
        checks++; if (dut.ptr !== 2'd0) begin failures++; $display("FAIL flush_ptr got=%0d exp=0", dut.ptr); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (dut.dict[k] !== 16'h0000) begin failures++; $display("FAIL flush_dict%0d got=%h exp=0000", k, dut.dict[k]); end
        end
        push(16'h00FF, 1'b0, 1'b0);
        checks++; if (out_data !== 16'h00FF) begin failures++; $display("FAIL post_flush_data got=%h exp=00ff", out_data); end
        checks++; if (out_idx !== 2'd0) begin failures++; $display("FAIL post_flush_idx got=%0d exp=0", out_idx); end
        checks++; if (dut.ptr !== 2'd1) begin failures++; $display("FAIL post_flush_ptr got=%0d exp=1", dut.ptr); end
    endtask

    task automatic test_async_reset();
        push(16'h1111, 1'b0, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ar_pre_valid got=%b exp=1", out_valid); end
        reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ar_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL ar_data got=%h exp=0000", out_data); end
        checks++; if (dut.ptr !== 2'd0) begin failures++; $display("FAIL ar_ptr got=%0d exp=0", dut.ptr); end
        #2;
        reset     = 1'b1;
        out_ready = 1'b1;
        push(16'h6396, 1'b0, 1'b0);
        checks++; if (out_data !== 16'h6396) begin failures++; $display("FAIL ar_after_data got=%h exp=6396", out_data); end
        checks++; if (out_idx !== 2'd0) begin failures++; $display("FAIL ar_after_idx got=%0d exp=0", out_idx); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ar_after_valid got=%b exp=1", out_valid); end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        bypass    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_stream();
        test_tie_break();
        test_wrap();
        test_backpressure();
        test_bypass_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
